pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised next-generation IF-stage program-counter generator.
- Adds a configurable reset vector, address width and instruction size.
- Adds a flush redirect with priority over branch, and capture of branches that arrive while fetch is held, so none are lost.
- Drives the instruction-memory address and chip enable for the IF stage.

Parameters:
- ADDR_W, 32: width of pc and all redirect addresses.
- RESET_VECTOR, 32'h8000_0000: pc value while reset is asserted and during the ce-disabled cycle; truncated to ADDR_W.
- INST_BYTES, 4: sequential increment; power of two, at least 1.
- STALL_W, 6: width of the pipeline stall vector. Only bit 0 (IF) is used here.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds the PC.
- flush  in  1  exception/ERET redirect request; ignores stall and ready.
- flush_addr  in  ADDR_W  flush target.
- branch_flag  in  1  branch/jump redirect request from ID.
- branch_addr  in  ADDR_W  branch target.
- if_ready  in  1  instruction memory accepts the current address this cycle.
- pc  out  ADDR_W  current fetch address, registered.
- ce  out  1  instruction memory chip enable, registered.
- redirect_pending  out  1  a captured branch is waiting to be applied.
- adel  out  1  misaligned fetch address flag, registered; see Optional Feature.

Behaviour:
- Reset (rst=1, asynchronous):
  - pc=RESET_VECTOR, ce=0.
  - Pending register cleared: redirect_pending=0, pend_addr=0.
  - adel=0.
- Two states:
  - S_OFF: ce=0; entered on reset.
  - S_RUN: ce=1.
- S_OFF -> S_RUN on the first rising edge with rst=0.
  - In that cycle pc stays RESET_VECTOR; flush and branch are ignored.
- Define adv = ce & ~stall[0] & if_ready.
- Next-pc priority on each edge in S_RUN:
  1. flush=1: pc<=flush_addr and the pending register is cleared. Applies regardless of stall and if_ready.
  2. adv=1 and branch_flag=1: pc<=branch_addr; pending cleared.
  3. adv=1 and pending valid: pc<=pend_addr; pending cleared.
  4. adv=1: pc<=pc+INST_BYTES, wrapping modulo 2^ADDR_W (all-ones region wraps to 0, no flag).
  5. adv=0 and branch_flag=1: pending<=branch_addr, valid=1. A newer branch overwrites an older pending one. pc holds.
  6. Otherwise pc holds.
- Simultaneous events:
  - Flush with branch_flag: flush wins; the branch is discarded, not captured.
  - branch_flag with a pending branch while adv=1: branch_flag wins.
- redirect_pending equals the registered pending-valid bit.
- Latency:
  - A redirect appears on pc one edge after it is accepted.
  - A captured branch appears one edge after the first adv=1 cycle.
- Reset asserted mid-operation: state returns to S_OFF immediately and all registers take their reset values.
- stall[STALL_W-1:1] are ignored.

Optional Feature:
- Macro: PC_ADEL_CHECK_EN. INST_BYTES=1 makes the check vacuous (adel always 0).
- Defined:
  - adel is registered alongside pc and equals (next_pc mod INST_BYTES != 0).
  - The misaligned pc is still presented and ce stays 1; downstream raises the AdEL exception.
  - adel clears on the next aligned update.
- Not defined:
  - adel is tied to 0.
  - All redirect targets have their low log2(INST_BYTES) bits forced to 0 before loading, so pc is always aligned.

Test Plan:
- Reset then release, no stall, if_ready=1 -> ce=0 and pc=0x80000000 in the first cycle; then ce=1 and pc=0x80000000, 0x80000004, 0x80000008 on successive edges.
- stall[0]=1 for 3 cycles with branch_flag=1 branch_addr=0x80001000 in cycle 1 only -> pc holds; redirect_pending=1; on release the next edge gives pc=0x80001000 and redirect_pending=0.
- flush=1 flush_addr=0xBFC00380 with stall[0]=1 and branch_flag=1 in the same cycle -> pc=0xBFC00380 next edge; pending stays 0.
- pc=0xFFFFFFFC, advancing -> pc=0x00000000.
- PC_ADEL_CHECK_EN defined, branch_addr=0x80000002 -> pc=0x80000002 with adel=1. Undefined: same stimulus -> pc=0x80000000, adel=0.
- rst pulsed high mid-run with a branch pending -> immediate pc=0x80000000, ce=0, redirect_pending=0, with no clock edge required.

Source files
------------

// File: rtl/pc_gen.sv
// IF-stage program-counter generator with flush/branch redirect and held-branch capture.
// Optional misaligned-fetch flag enabled by defining PC_ADEL_CHECK_EN.
module pc_gen #(
    parameter int          ADDR_W       = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter int          INST_BYTES   = 4,
    parameter int          STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               if_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending,
    output logic               adel
);

    localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    if ((INST_BYTES < 1) || ((INST_BYTES & (INST_BYTES - 1)) != 0)) begin : g_bad_inst_bytes
        $error("pc_gen: INST_BYTES must be a power of two");
    end

    typedef enum logic {
        S_OFF,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ce_next;
    logic [ADDR_W-1:0] pc_next;
    logic              pend_valid;
    logic              pend_valid_next;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] pend_addr_next;
    logic [ADDR_W-1:0] flush_tgt;
    logic [ADDR_W-1:0] branch_tgt;
    logic              adv;
    logic              unused_stall;

    // Only the IF bit of the stall vector matters to this stage.
    assign unused_stall = ^stall;

`ifdef PC_ADEL_CHECK_EN
    assign flush_tgt  = flush_addr;
    assign branch_tgt = branch_addr;
`else
    assign flush_tgt  = flush_addr & ~ALIGN_MASK;
    assign branch_tgt = branch_addr & ~ALIGN_MASK;
`endif

    assign adv              = ce & ~stall[0] & if_ready;
    assign redirect_pending = pend_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_OFF;
            ce         <= 1'b0;
            pc         <= RST_PC;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            state      <= state_next;
            ce         <= ce_next;
            pc         <= pc_next;
            pend_valid <= pend_valid_next;
            pend_addr  <= pend_addr_next;
        end
    end

    // Redirect priority: flush, then live branch, then captured branch, then sequential.
    always_comb begin
        state_next      = state;
        ce_next         = ce;
        pc_next         = pc;
        pend_valid_next = pend_valid;
        pend_addr_next  = pend_addr;
        case (state)
            S_OFF: begin
                state_next = S_RUN;
                ce_next    = 1'b1;
                pc_next    = RST_PC;
            end
            S_RUN: begin
                ce_next = 1'b1;
                if (flush) begin
                    pc_next         = flush_tgt;
                    pend_valid_next = 1'b0;
                end else if (adv && branch_flag) begin
                    pc_next         = branch_tgt;
                    pend_valid_next = 1'b0;
                end else if (adv && pend_valid) begin
                    pc_next         = pend_addr;
                    pend_valid_next = 1'b0;
                end else if (adv) begin
                    pc_next = pc + STEP;
                end else if (branch_flag) begin
                    pend_valid_next = 1'b1;
                    pend_addr_next  = branch_tgt;
                end
            end
            default: begin
                state_next = S_OFF;
                ce_next    = 1'b0;
                pc_next    = RST_PC;
            end
        endcase
    end

`ifdef PC_ADEL_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adel <= 1'b0;
        end else begin
            adel <= |(pc_next & ALIGN_MASK);
        end
    end
`else
    assign adel = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a reference model.
// Expected adel/alignment behaviour follows PC_ADEL_CHECK_EN when defined.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h8000_0000;

`ifdef PC_ADEL_CHECK_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_addr;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        if_ready;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pending;
    logic        adel;

    int checks = 0;
    int passed = 0;

    bit          m_run;
    logic [31:0] m_pc;
    bit          m_pv;
    logic [31:0] m_pa;
    bit          m_adel;

    pc_gen dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .flush(flush),
        .flush_addr(flush_addr),
        .branch_flag(branch_flag),
        .branch_addr(branch_addr),
        .if_ready(if_ready),
        .pc(pc),
        .ce(ce),
        .redirect_pending(redirect_pending),
        .adel(adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] align(input logic [31:0] a);
        if (ADEL_EN) return a;
        return a - (a % 4);
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_pc   = RV;
        m_pv   = 1'b0;
        m_pa   = '0;
        m_adel = 1'b0;
    endtask

    // Reference behaviour for one rising edge given the inputs currently driven.
    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            m_run = 1'b1;
            m_pc  = RV;
        end else if (flush) begin
            m_pc = align(flush_addr);
            m_pv = 1'b0;
        end else if (!stall[0] && if_ready) begin
            if (branch_flag) begin
                m_pc = align(branch_addr);
                m_pv = 1'b0;
            end else if (m_pv) begin
                m_pc = m_pa;
                m_pv = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (branch_flag) begin
            m_pv = 1'b1;
            m_pa = align(branch_addr);
        end
        m_adel = ADEL_EN && ((m_pc % 4) != 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = '0;
        flush       = 1'b0;
        flush_addr  = '0;
        branch_flag = 1'b0;
        branch_addr = '0;
        if_ready    = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (pc !== RV) $display("[TB] FAIL reset_pc: got %h expected %h", pc, RV);
        else passed++;
        checks++;
        if (ce !== 1'b0) $display("[TB] FAIL reset_ce: got %b expected 0", ce);
        else passed++;
        checks++;
        if (redirect_pending !== 1'b0) $display("[TB] FAIL reset_pending: got %b expected 0", redirect_pending);
        else passed++;
        checks++;
        if (adel !== 1'b0) $display("[TB] FAIL reset_adel: got %b expected 0", adel);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if (ce !== 1'b0 || pc !== RV) $display("[TB] FAIL off_cycle: got ce=%b pc=%h expected ce=0 pc=%h", ce, pc, RV);
        else passed++;
        tick();
        checks++;
        if (ce !== 1'b1 || pc !== RV) $display("[TB] FAIL first_run: got ce=%b pc=%h expected ce=1 pc=%h", ce, pc, RV);
        else passed++;
        tick();
        checks++;
        if (pc !== 32'h8000_0004) $display("[TB] FAIL seq_1: got %h expected 80000004", pc);
        else passed++;
        tick();
        checks++;
        if (pc !== 32'h8000_0008) $display("[TB] FAIL seq_2: got %h expected 80000008", pc);
        else passed++;
    endtask

    task automatic test_stall_capture();
        logic [31:0] held;
        held        = pc;
        stall       = 6'b000001;
        branch_flag = 1'b1;
        branch_addr = 32'h8000_1000;
        tick();
        branch_flag = 1'b0;
        tick();
        tick();
        checks++;
        if (pc !== held) $display("[TB] FAIL stall_hold: got %h expected %h", pc, held);
        else passed++;
        checks++;
        if (redirect_pending !== 1'b1) $display("[TB] FAIL stall_pending: got %b expected 1", redirect_pending);
        else passed++;
        stall = '0;
        tick();
        checks++;
        if (pc !== 32'h8000_1000) $display("[TB] FAIL pending_apply: got %h expected 80001000", pc);
        else passed++;
        checks++;
        if (redirect_pending !== 1'b0) $display("[TB] FAIL pending_clear: got %b expected 0", redirect_pending);
        else passed++;
    endtask

    task automatic test_flush_priority();
        stall       = 6'b000001;
        flush       = 1'b1;
        flush_addr  = 32'hBFC0_0380;
        branch_flag = 1'b1;
        branch_addr = 32'h1234_5678;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'hBFC0_0380) $display("[TB] FAIL flush_pc: got %h expected bfc00380", pc);
        else passed++;
        checks++;
        if (redirect_pending !== 1'b0) $display("[TB] FAIL flush_pending: got %b expected 0", redirect_pending);
        else passed++;
    endtask

    task automatic test_wrap();
        branch_flag = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        tick();
        branch_flag = 1'b0;
        checks++;
        if (pc !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_load: got %h expected fffffffc", pc);
        else passed++;
        tick();
        checks++;
        if (pc !== 32'h0000_0000) $display("[TB] FAIL wrap_zero: got %h expected 00000000", pc);
        else passed++;
    endtask

    task automatic test_misaligned();
        logic [31:0] exp_pc;
        logic        exp_adel;
        exp_pc      = ADEL_EN ? 32'h8000_0002 : 32'h8000_0000;
        exp_adel    = ADEL_EN;
        branch_flag = 1'b1;
        branch_addr = 32'h8000_0002;
        tick();
        branch_flag = 1'b0;
        checks++;
        if (pc !== exp_pc) $display("[TB] FAIL misalign_pc: got %h expected %h", pc, exp_pc);
        else passed++;
        checks++;
        if (adel !== exp_adel) $display("[TB] FAIL misalign_adel: got %b expected %b", adel, exp_adel);
        else passed++;
        branch_flag = 1'b1;
        branch_addr = 32'h8000_0100;
        tick();
        branch_flag = 1'b0;
        checks++;
        if (adel !== 1'b0) $display("[TB] FAIL adel_clear: got %b expected 0", adel);
        else passed++;
    endtask

    task automatic test_async_reset();
        stall       = 6'b000001;
        branch_flag = 1'b1;
        branch_addr = 32'h8000_2000;
        tick();
        branch_flag = 1'b0;
        checks++;
        if (redirect_pending !== 1'b1) $display("[TB] FAIL pre_reset_pending: got %b expected 1", redirect_pending);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (pc !== RV || ce !== 1'b0 || redirect_pending !== 1'b0)
            $display("[TB] FAIL async_reset: got pc=%h ce=%b pend=%b expected pc=%h ce=0 pend=0",
                     pc, ce, redirect_pending, RV);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if (ce !== 1'b1 || pc !== RV) $display("[TB] FAIL restart: got ce=%b pc=%h expected ce=1 pc=%h", ce, pc, RV);
        else passed++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            flush       = ($urandom_range(15) == 0);
            flush_addr  = $urandom();
            branch_flag = ($urandom_range(3) == 0);
            branch_addr = ($urandom_range(3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            stall       = 6'($urandom()) & 6'b111110;
            stall[0]    = ($urandom_range(2) == 0);
            if_ready    = ($urandom_range(3) != 0);
            tick();
            checks++;
            if (pc !== m_pc || ce !== m_run || redirect_pending !== m_pv || adel !== m_adel) begin
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_%0d: got pc=%h ce=%b pend=%b adel=%b expected pc=%h ce=%b pend=%b adel=%b",
                             i, pc, ce, redirect_pending, adel, m_pc, m_run, m_pv, m_adel);
            end else begin
                passed++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stall_capture();
        test_flush_priority();
        test_wrap();
        test_misaligned();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
